frame_ctrl: RTL

Frame-synchronous configuration and scroll controller for the VGA pixel path. It accepts register writes over a valid/ready port into shadow registers and commits them atomically on each vsync rising edge, so mid-frame writes never tear the picture. It also advances per-frame X/Y scroll offsets and a frame counter. It sits between the host/input logic and the pattern generator, which consumes `x_off`, `y_off` and `pattern` alongside the timing generator's x/y.

---
 rtl/frame_ctrl_pkg.sv | 45 ++++
 rtl/frame_ctrl_scroll_axis.sv | 30 +++
 rtl/frame_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/frame_ctrl_pkg.sv
// Shared definitions for frame_ctrl: register map, CTRL bit positions, FSM states, config struct.
package frame_ctrl_pkg;

    localparam logic [2:0] FC_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] FC_ADDR_X_STEP = 3'd1;
    localparam logic [2:0] FC_ADDR_Y_STEP = 3'd2;
    localparam logic [2:0] FC_ADDR_CMD    = 3'd3;

    localparam int CTRL_X_EN   = 0;
    localparam int CTRL_Y_EN   = 1;
    localparam int CTRL_X_DIR  = 2;
    localparam int CTRL_Y_DIR  = 3;
    localparam int CTRL_PAT_LO = 4;
    localparam int CTRL_RSVD   = 6;
    localparam int CTRL_FREEZE = 7;

    typedef enum logic [1:0] {
        FC_IDLE,
        FC_DIRTY,
        FC_COMMIT
    } fc_state_t;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] x_step;
        logic [7:0] y_step;
    } fc_cfg_t;

    localparam fc_cfg_t FC_CFG_RST = {8'h00, 8'h01, 8'h01};

    // Addresses 3..7 leave the config untouched; CMD is held outside the struct.
    function automatic fc_cfg_t fc_cfg_write(input fc_cfg_t cfg, input logic [2:0] addr,
                                             input logic [7:0] data);
        fc_cfg_t r;
        r = cfg;
        case (addr)
            FC_ADDR_CTRL:   r.ctrl   = data;
            FC_ADDR_X_STEP: r.x_step = data;
            FC_ADDR_Y_STEP: r.y_step = data;
            default:        ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frame_ctrl_scroll_axis.sv
// One scroll axis: offset register with clear and modulo-2^OFF_W step add/subtract.
module scroll_axis #(
    parameter int OFF_W  = 11,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              clear,
    input  logic              advance,
    output logic [OFF_W-1:0]  off
);

    logic [OFF_W-1:0] step_ext;

    assign step_ext = OFF_W'(step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off <= '0;
        end else if (clear) begin
            off <= '0;
        end else if (advance && en) begin
            off <= dir ? (off - step_ext) : (off + step_ext);
        end
    end

endmodule

// File: rtl/frame_ctrl.sv
// Frame-synchronous config/scroll controller; config and offsets change only on a vsync rise.
// FRAME_CTRL_SHADOW_EN: double-buffered shadow registers. Undefined: writes go straight to active.
//
// state     | meaning
// FC_IDLE   | shadow equals active
// FC_DIRTY  | accepted write since last commit
// FC_COMMIT | single-cycle commit / advance
module frame_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int OFF_W  = 11,
    parameter int STEP_W = 8,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [OFF_W-1:0]  x_off,
    output logic [OFF_W-1:0]  y_off,
    output logic [1:0]        pattern,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              commit,
    output logic              pending
);

    fc_state_t state;
    fc_cfg_t   cfg_src;
    logic      vsync_d, clr_req;
    logic      accept, vs_rise, in_commit, clr_hit, adv;
    logic      unused_rsvd;

    assign vs_rise     = vsync & ~vsync_d;
    assign in_commit   = (state == FC_COMMIT);
    assign accept      = wr_valid & wr_ready;
    assign clr_hit     = in_commit & clr_req;
    assign adv         = in_commit & ~clr_req & ~cfg_src.ctrl[CTRL_FREEZE];
    assign unused_rsvd = cfg_src.ctrl[CTRL_RSVD];

`ifdef FRAME_CTRL_SHADOW_EN
    fc_cfg_t    cfg_sh;
    logic [1:0] pat_act;
    logic       ready_q, pending_q;

    // Offsets only move at commit, so the advance reads the shadow being committed.
    assign cfg_src  = cfg_sh;
    assign pattern  = pat_act;
    assign wr_ready = ready_q;
    assign pending  = pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_sh  <= FC_CFG_RST;
            pat_act <= 2'd0;
            clr_req <= 1'b0;
        end else if (in_commit) begin
            pat_act <= cfg_sh.ctrl[CTRL_PAT_LO +: 2];
            clr_req <= 1'b0;
        end else if (accept) begin
            cfg_sh <= fc_cfg_write(cfg_sh, wr_addr, wr_data);
            if (wr_addr == FC_ADDR_CMD) clr_req <= wr_data[0];
        end
    end
`else
    fc_cfg_t cfg_act;

    // Registered value is the pre-write config when a write lands in the commit cycle.
    assign cfg_src  = cfg_act;
    assign pattern  = cfg_act.ctrl[CTRL_PAT_LO +: 2];
    assign wr_ready = 1'b1;
    assign pending  = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_act <= FC_CFG_RST;
            clr_req <= 1'b0;
        end else begin
            if (accept) cfg_act <= fc_cfg_write(cfg_act, wr_addr, wr_data);
            if (accept && wr_addr == FC_ADDR_CMD) clr_req <= wr_data[0];
            else if (in_commit)                   clr_req <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FC_IDLE;
            vsync_d <= 1'b0;
            commit  <= 1'b0;
`ifdef FRAME_CTRL_SHADOW_EN
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
`endif
        end else begin
            vsync_d <= vsync;
            commit  <= 1'b0;
`ifdef FRAME_CTRL_SHADOW_EN
            ready_q   <= 1'b1;
            pending_q <= in_commit ? 1'b0 : (pending_q | accept);
`endif
            case (state)
                FC_IDLE, FC_DIRTY: begin
                    if (vs_rise) begin
                        state  <= FC_COMMIT;
                        commit <= 1'b1;
`ifdef FRAME_CTRL_SHADOW_EN
                        ready_q <= 1'b0;
`endif
                    end else if (accept) begin
                        state <= FC_DIRTY;
                    end
                end
                default: state <= FC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         frame_cnt <= '0;
        else if (in_commit) frame_cnt <= frame_cnt + FCNT_W'(1);
    end

    scroll_axis #(.OFF_W(OFF_W), .STEP_W(STEP_W)) u_x_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (cfg_src.ctrl[CTRL_X_EN]),
        .dir     (cfg_src.ctrl[CTRL_X_DIR]),
        .step    (STEP_W'(cfg_src.x_step)),
        .clear   (clr_hit),
        .advance (adv),
        .off     (x_off)
    );

    scroll_axis #(.OFF_W(OFF_W), .STEP_W(STEP_W)) u_y_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (cfg_src.ctrl[CTRL_Y_EN]),
        .dir     (cfg_src.ctrl[CTRL_Y_DIR]),
        .step    (STEP_W'(cfg_src.y_step)),
        .clear   (clr_hit),
        .advance (adv),
        .off     (y_off)
    );

endmodule
